itch_event_queue: RTL and testbench

Downstream stage of the speculative ITCH decoders (add, cancel, delete, replace). Captures each decoder's one-cycle `*_internal_valid` pulse with its fields, normalises it into a single order-event record, and buffers records in a small FIFO. Records leave on a valid/ready interface toward the order-book engine. Overflow and collision conditions are flagged rather than stalling, because the byte stream has no backpressure.

---
 rtl/itch_pkg.sv | 20 ++
 rtl/event_fifo.sv | 62 ++++++
 rtl/itch_event_queue.sv | 119 +++++++++++
 tb/tb_itch_event_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared types for the ITCH decode path: message-type codes and the
// normalised order-event record carried from the decoders to the book engine.
package itch_pkg;

  localparam logic [7:0] MSG_ADD     = 8'h41;  // 'A'
  localparam logic [7:0] MSG_CANCEL  = 8'h58;  // 'X'
  localparam logic [7:0] MSG_DELETE  = 8'h44;  // 'D'
  localparam logic [7:0] MSG_REPLACE = 8'h55;  // 'U'

  // 8 + 64 + 64 + 32 + 32 + 1 = 201 bits
  typedef struct packed {
    logic [7:0]  msg_type;
    logic [63:0] order_ref;
    logic [63:0] new_order_ref;
    logic [31:0] shares;
    logic [31:0] price;
    logic        side;
  } order_event_t;

endpackage

// File: rtl/event_fifo.sv
// Circular FIFO of order_event_t records. A push while full is accepted
// only when a pop frees the head slot in the same cycle.
module event_fifo
  import itch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  order_event_t             push_data,
  input  logic                     pop,
  output order_event_t             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  order_event_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when empty so stale or unreset storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/itch_event_queue.sv
// Merges the four speculative ITCH decoder pulses into one prioritised
// order-event stream, buffered for the order-book engine with drop/collision flags.
module itch_event_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     add_valid,
  input  logic [63:0]              add_order_ref,
  input  logic                     add_side,
  input  logic [31:0]              add_shares,
  input  logic [31:0]              add_price,
  input  logic                     cancel_valid,
  input  logic [63:0]              cancel_order_ref,
  input  logic [31:0]              cancel_shares,
  input  logic                     delete_valid,
  input  logic [63:0]              delete_order_ref,
  input  logic                     replace_valid,
  input  logic [63:0]              replace_old_order_ref,
  input  logic [63:0]              replace_new_order_ref,
  input  logic [31:0]              replace_shares,
  input  logic [31:0]              replace_price,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_type,
  output logic [63:0]              out_order_ref,
  output logic [63:0]              out_new_order_ref,
  output logic [31:0]              out_shares,
  output logic [31:0]              out_price,
  output logic                     out_side,
  output logic                     overflow,
  output logic                     collision,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  import itch_pkg::*;

  order_event_t cand;
  order_event_t head;
  logic [3:0]   valids;
  logic         push;
  logic         pop;
  logic         multi_valid;
  logic         fifo_full;
  logic         fifo_empty;
  logic         drop;

  assign valids      = {replace_valid, add_valid, cancel_valid, delete_valid};
  assign push        = |valids;
  assign multi_valid = ($countones(valids) > 1);

  // Only one record per cycle can enter; replace wins, then add, cancel, delete.
  always_comb begin
    cand = '0;
    if (replace_valid) begin
      cand.msg_type      = MSG_REPLACE;
      cand.order_ref     = replace_old_order_ref;
      cand.new_order_ref = replace_new_order_ref;
      cand.shares        = replace_shares;
      cand.price         = replace_price;
    end else if (add_valid) begin
      cand.msg_type      = MSG_ADD;
      cand.order_ref     = add_order_ref;
      cand.shares        = add_shares;
      cand.price         = add_price;
      cand.side          = add_side;
    end else if (cancel_valid) begin
      cand.msg_type      = MSG_CANCEL;
      cand.order_ref     = cancel_order_ref;
      cand.shares        = cancel_shares;
    end else if (delete_valid) begin
      cand.msg_type      = MSG_DELETE;
      cand.order_ref     = delete_order_ref;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign out_type          = head.msg_type;
  assign out_order_ref     = head.order_ref;
  assign out_new_order_ref = head.new_order_ref;
  assign out_shares        = head.shares;
  assign out_price         = head.price;
  assign out_side          = head.side;

  // The byte stream cannot be stalled, so losses are reported, never back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      collision  <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow  <= drop;
      collision <= multi_valid;
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_itch_event_queue.sv
// Directed plus short random test of itch_event_queue against a scoreboard
// of expected records and flag/counter predictions.
module tb_itch_event_queue;

  import itch_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              add_valid;
  logic [63:0]       add_order_ref;
  logic              add_side;
  logic [31:0]       add_shares;
  logic [31:0]       add_price;
  logic              cancel_valid;
  logic [63:0]       cancel_order_ref;
  logic [31:0]       cancel_shares;
  logic              delete_valid;
  logic [63:0]       delete_order_ref;
  logic              replace_valid;
  logic [63:0]       replace_old_order_ref;
  logic [63:0]       replace_new_order_ref;
  logic [31:0]       replace_shares;
  logic [31:0]       replace_price;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_type;
  logic [63:0]       out_order_ref;
  logic [63:0]       out_new_order_ref;
  logic [31:0]       out_shares;
  logic [31:0]       out_price;
  logic              out_side;
  logic              overflow;
  logic              collision;
  logic [CNT_W-1:0]  drop_count;
  logic [LVL_W-1:0]  level;

  int checks = 0;
  int errors = 0;

  order_event_t sb[$];
  logic         exp_overflow = 1'b0;
  logic         exp_collision = 1'b0;
  int           exp_drops = 0;

  itch_event_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .add_valid             (add_valid),
    .add_order_ref         (add_order_ref),
    .add_side              (add_side),
    .add_shares            (add_shares),
    .add_price             (add_price),
    .cancel_valid          (cancel_valid),
    .cancel_order_ref      (cancel_order_ref),
    .cancel_shares         (cancel_shares),
    .delete_valid          (delete_valid),
    .delete_order_ref      (delete_order_ref),
    .replace_valid         (replace_valid),
    .replace_old_order_ref (replace_old_order_ref),
    .replace_new_order_ref (replace_new_order_ref),
    .replace_shares        (replace_shares),
    .replace_price         (replace_price),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_type              (out_type),
    .out_order_ref         (out_order_ref),
    .out_new_order_ref     (out_new_order_ref),
    .out_shares            (out_shares),
    .out_price             (out_price),
    .out_side              (out_side),
    .overflow              (overflow),
    .collision             (collision),
    .drop_count            (drop_count),
    .level                 (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    add_valid = 1'b0; add_order_ref = '0; add_side = 1'b0; add_shares = '0; add_price = '0;
    cancel_valid = 1'b0; cancel_order_ref = '0; cancel_shares = '0;
    delete_valid = 1'b0; delete_order_ref = '0;
    replace_valid = 1'b0; replace_old_order_ref = '0; replace_new_order_ref = '0;
    replace_shares = '0; replace_price = '0;
  endtask

  task automatic driveAdd(input logic [63:0] r, input logic s, input logic [31:0] sh, input logic [31:0] p);
    add_valid = 1'b1; add_order_ref = r; add_side = s; add_shares = sh; add_price = p;
  endtask

  // Record the winning input would produce, built from the message definitions.
  function automatic order_event_t expectedEvent();
    order_event_t e;
    e = '0;
    if (replace_valid) begin
      e.msg_type = 8'h55; e.order_ref = replace_old_order_ref;
      e.new_order_ref = replace_new_order_ref; e.shares = replace_shares; e.price = replace_price;
    end else if (add_valid) begin
      e.msg_type = 8'h41; e.order_ref = add_order_ref; e.shares = add_shares;
      e.price = add_price; e.side = add_side;
    end else if (cancel_valid) begin
      e.msg_type = 8'h58; e.order_ref = cancel_order_ref; e.shares = cancel_shares;
    end else if (delete_valid) begin
      e.msg_type = 8'h44; e.order_ref = delete_order_ref;
    end
    return e;
  endfunction

  task automatic checkModel();
    checkOutput("level", 64'(level), 64'(sb.size()));
    checkOutput("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    checkOutput("overflow", 64'(overflow), 64'(exp_overflow));
    checkOutput("collision", 64'(collision), 64'(exp_collision));
    checkOutput("drop_count", 64'(drop_count), 64'(exp_drops));
    if (sb.size() != 0) begin
      checkOutput("head_type", 64'(out_type), 64'(sb[0].msg_type));
      checkOutput("head_ref", out_order_ref, sb[0].order_ref);
      checkOutput("head_new_ref", out_new_order_ref, sb[0].new_order_ref);
      checkOutput("head_shares", 64'(out_shares), 64'(sb[0].shares));
      checkOutput("head_price", 64'(out_price), 64'(sb[0].price));
      checkOutput("head_side", 64'(out_side), 64'(sb[0].side));
    end
  endtask

  // Commit the inputs currently driven through one clock edge, update the
  // scoreboard, then check the DUT at the following falling edge.
  task automatic applyStimulus();
    order_event_t ev;
    int           nv;
    logic         pop_m;
    logic         accept;
    ev     = expectedEvent();
    nv     = int'(add_valid) + int'(cancel_valid) + int'(delete_valid) + int'(replace_valid);
    pop_m  = (sb.size() != 0) && out_ready;
    accept = (sb.size() < DEPTH) || pop_m;
    if (rst) begin
      sb.delete();
      exp_overflow  = 1'b0;
      exp_collision = 1'b0;
      exp_drops     = 0;
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (nv != 0 && accept) sb.push_back(ev);
      exp_overflow  = (nv != 0) && !accept;
      exp_collision = (nv > 1);
      if (exp_overflow && exp_drops < 65535) exp_drops++;
    end
    @(negedge clk);
    clearInputs();
    checkModel();
  endtask

  initial begin
    clearInputs();
    out_ready = 1'b0;
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_drops", 64'(drop_count), 64'd0);
    checkOutput("rst_type", 64'(out_type), 64'd0);
    checkOutput("rst_ref", out_order_ref, 64'd0);

    // Single replace
    out_ready = 1'b1;
    replace_valid = 1'b1; replace_old_order_ref = 64'h11; replace_new_order_ref = 64'h22;
    replace_shares = 32'd100; replace_price = 32'h1F4;
    applyStimulus();
    checkOutput("rep_valid", 64'(out_valid), 64'd1);
    checkOutput("rep_type", 64'(out_type), 64'h55);
    checkOutput("rep_old", out_order_ref, 64'h11);
    checkOutput("rep_new", out_new_order_ref, 64'h22);
    checkOutput("rep_shares", 64'(out_shares), 64'd100);
    checkOutput("rep_price", 64'(out_price), 64'h1F4);
    checkOutput("rep_level1", 64'(level), 64'd1);
    applyStimulus();
    checkOutput("rep_level0", 64'(level), 64'd0);

    // Ordering A, X, D held back then drained
    out_ready = 1'b0;
    driveAdd(64'h100, 1'b1, 32'd10, 32'h200);
    applyStimulus();
    cancel_valid = 1'b1; cancel_order_ref = 64'h101; cancel_shares = 32'd5;
    applyStimulus();
    delete_valid = 1'b1; delete_order_ref = 64'h102;
    applyStimulus();
    checkOutput("ord_level3", 64'(level), 64'd3);
    out_ready = 1'b1;
    checkOutput("ord_typeA", 64'(out_type), 64'h41);
    checkOutput("ord_sideA", 64'(out_side), 64'd1);
    applyStimulus();
    checkOutput("ord_typeX", 64'(out_type), 64'h58);
    checkOutput("ord_priceX", 64'(out_price), 64'd0);
    checkOutput("ord_sharesX", 64'(out_shares), 64'd5);
    applyStimulus();
    checkOutput("ord_typeD", 64'(out_type), 64'h44);
    checkOutput("ord_sharesD", 64'(out_shares), 64'd0);
    checkOutput("ord_newrefD", out_new_order_ref, 64'd0);
    applyStimulus();
    checkOutput("ord_level0", 64'(level), 64'd0);

    // Overflow: nine pushes into eight slots
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      driveAdd(64'h1000 + 64'(i), 1'b0, 32'(i + 1), 32'h300);
      applyStimulus();
    end
    checkOutput("ovf_level", 64'(level), 64'd8);
    checkOutput("ovf_pulse", 64'(overflow), 64'd1);
    checkOutput("ovf_drops", 64'(drop_count), 64'd1);
    checkOutput("ovf_head", out_order_ref, 64'h1000);
    applyStimulus();
    checkOutput("ovf_pulse_end", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    driveAdd(64'h2000, 1'b1, 32'd7, 32'h400);
    applyStimulus();
    checkOutput("fpp_overflow", 64'(overflow), 64'd0);
    checkOutput("fpp_level", 64'(level), 64'd8);
    checkOutput("fpp_head", out_order_ref, 64'h1001);
    for (int i = 0; i < 7; i++) applyStimulus();
    checkOutput("fpp_tail", out_order_ref, 64'h2000);
    applyStimulus();
    checkOutput("fpp_drained", 64'(level), 64'd0);

    // Collision: add and replace together
    out_ready = 1'b0;
    driveAdd(64'h500, 1'b1, 32'd1, 32'd1);
    replace_valid = 1'b1; replace_old_order_ref = 64'h600; replace_new_order_ref = 64'h601;
    replace_shares = 32'd2; replace_price = 32'd3;
    applyStimulus();
    checkOutput("col_pulse", 64'(collision), 64'd1);
    checkOutput("col_level", 64'(level), 64'd1);
    checkOutput("col_type", 64'(out_type), 64'h55);
    checkOutput("col_drops", 64'(drop_count), 64'd1);
    applyStimulus();
    checkOutput("col_pulse_end", 64'(collision), 64'd0);
    out_ready = 1'b1;
    applyStimulus();

    // Reset mid-burst
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      driveAdd(64'h700 + 64'(i), 1'b0, 32'd9, 32'd9);
      applyStimulus();
    end
    checkOutput("rmb_level5", 64'(level), 64'd5);
    rst = 1'b1;
    driveAdd(64'h7FF, 1'b1, 32'd1, 32'd1);
    applyStimulus();
    rst = 1'b0;
    checkOutput("rmb_valid", 64'(out_valid), 64'd0);
    checkOutput("rmb_level", 64'(level), 64'd0);
    checkOutput("rmb_drops", 64'(drop_count), 64'd0);
    checkOutput("rmb_type", 64'(out_type), 64'd0);
    out_ready = 1'b1;
    driveAdd(64'h3000, 1'b1, 32'd4, 32'd8);
    applyStimulus();
    checkOutput("rmb_next_type", 64'(out_type), 64'h41);
    checkOutput("rmb_next_ref", out_order_ref, 64'h3000);
    applyStimulus();
    checkOutput("rmb_next_level", 64'(level), 64'd0);

    // Random traffic with occasional collisions and backpressure
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) driveAdd({$urandom, $urandom}, 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        cancel_valid = 1'b1; cancel_order_ref = {$urandom, $urandom}; cancel_shares = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        delete_valid = 1'b1; delete_order_ref = {$urandom, $urandom};
      end
      if ($urandom_range(0, 4) == 0) begin
        replace_valid = 1'b1; replace_old_order_ref = {$urandom, $urandom};
        replace_new_order_ref = {$urandom, $urandom};
        replace_shares = $urandom; replace_price = $urandom;
      end
      applyStimulus();
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus();
    checkOutput("final_level", 64'(level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
